demux1to2_stream: RTL and testbench
===================================

# demux1to2_stream

Handshaked 1-to-2 demultiplexer: the routing counterpart of the datapath 2-to-1 mux. It accepts one N-bit word per cycle on a valid/ready input and steers it to one of two output channels, selected by a 2-bit code. Each output channel has its own one-entry registered slot, so a stalled consumer on one channel never corrupts data on the other. It sits between a single producer stage and two consumer stages.

## Interface
- `N`, 32, data width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted this cycle when high with `in_valid`.
- `in_sel`  in  2  route code: 2'b00 → channel 0, 2'b01 → channel 1, 2'b10/2'b11 → invalid.
- `in_data`  in  N  input word.
- `out0_valid` / `out1_valid`  out  1  slot holds a word.
- `out0_ready` / `out1_ready`  in  1  consumer takes the word.
- `out0_data` / `out1_data`  out  N  slot contents.
- `drop`  out  1  registered pulse: one invalid-code word was consumed in the previous cycle.
- `drop_count`  out  16  saturating count of dropped words (only with `DEMUX_DROP_CNT_EN`).

## Operation
- Each channel slot is either EMPTY or FULL. `outX_valid` is high exactly when slot X is FULL.
- Input transfer: `in_valid && in_ready` on a rising edge.
- `in_ready`:
  - For sel 00/01: high when the target slot is EMPTY, or FULL with its `outX_ready` high in the same cycle.
  - For an invalid sel: always high.
  - Combinational in `in_sel` and `outX_ready`; it has no dependence on `in_valid`.
- Load on a transfer with sel 00/01: the target slot becomes FULL and takes `in_data`. The other slot is untouched.
- Output transfer `outX_valid && outX_ready`:
  - With no simultaneous load, slot X goes EMPTY.
  - With a simultaneous load into X, slot X stays FULL and holds the new word.
- Invalid sel on a transfer: the word is discarded, neither slot changes, and `drop` pulses high for exactly the next cycle.
- While `outX_valid` is high and `outX_ready` is low, `outX_data` is held stable.
- `outX_data` is zero whenever slot X is EMPTY after a drain.
- `in_sel` and `in_data` are only sampled on a transfer.
- Ordering is preserved per channel. There is no ordering guarantee across the two channels.

## Timing
- Reset value of every output: `outX_valid`=0, `outX_data`=0, `drop`=0, `drop_count`=0. `in_ready` is therefore 1 for any sel.
- Latency: a word accepted at edge k is visible on `outX_valid`/`outX_data` immediately after edge k (one register stage).
- Throughput: one word per cycle sustained on a channel whose consumer holds `outX_ready` high.
- A full slot with its consumer stalled back-pressures only inputs targeting that slot.
- Reset asserted mid-operation clears both slots and the counter asynchronously. Buffered words are lost, and no partial state survives deassertion.

## Configuration
- Macro: `DEMUX_DROP_CNT_EN`.
- Defined:
  - The `drop_count` port exists.
  - It increments by 1 on each invalid-sel transfer and saturates at 16'hFFFF (no wrap).
  - It is cleared only by reset.
- Undefined: the `drop_count` port and its register are absent. `drop` still behaves as above.

## Structure
- The shared package holds:
  - the sel encodings: `SEL_CH0`=2'b00, `SEL_CH1`=2'b01;
  - the counter width constant `DROP_CNT_W`=16;
  - the slot state enum {EMPTY, FULL}.
- Sub-module `demux_out_slot` holds one EMPTY/FULL slot with the load/drain/simultaneous rules and the data register. It is parameterized by `N` and instantiated twice.
- The top level holds the sel decode, `in_ready` generation, `drop` and the optional counter.

## Test plan
- Reset: hold `rst_n`=0, then release → both valids 0, data 0, `drop` 0, and `in_ready`=1 for sel 00, 01 and 10.
- Route: sel 00 with data 32'hDEADBEEF, `out0_ready`=1 → `out0_valid` high with DEADBEEF for one cycle after the edge, and `out1_valid` stays 0.
- Backpressure: `out1_ready`=0, then send 32'h1 and 32'h2 with sel 01:
  - 32'h1 is latched and `in_ready` drops for 32'h2;
  - `out1_data` holds 32'h1 while stalled;
  - raising `out1_ready` accepts 32'h2 in the same cycle, and 32'h2 appears on the next edge.
- Simultaneous drain and load: slot 0 FULL with 32'hA, `out0_ready`=1, input 32'hB with sel 00 → `in_ready`=1, and after the edge `out0_valid`=1 with `out0_data`=32'hB.
- Invalid sel: sel 2'b10 with data 32'h5 → accepted, slots unchanged, `drop` high for one cycle. With `DEMUX_DROP_CNT_EN`, `drop_count` goes 0→1, and after preloading to 16'hFFFF a further drop keeps it at 16'hFFFF.
- Asynchronous reset mid-op: both slots FULL and stalled, assert `rst_n`=0 between edges → both valids 0 immediately, no word emitted after deassertion.

Source files
------------

// File: rtl/demux1to2_stream_pkg.sv
// rtl/demux1to2_stream_pkg.sv - shared route codes, counter width and slot state for the 1-to-2 stream demux
package demux1to2_stream_pkg;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;

  localparam int DROP_CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry registered output slot with load/drain/simultaneous handling
module demux_out_slot
  import demux1to2_stream_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] wdata,
  input  logic         ready,
  output logic         free,
  output logic         valid,
  output logic [N-1:0] data
);

  slot_state_t state;

  assign valid = (state == FULL);
  // A full slot can take a new word in the same cycle its consumer drains it.
  assign free  = (state == EMPTY) || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
    end else if (load) begin
      state <= FULL;
      data  <= wdata;
    end else if (state == FULL && ready) begin
      // Drained slots read as zero so stale words never linger on the bus.
      state <= EMPTY;
      data  <= '0;
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// rtl/demux1to2_stream.sv - handshaked 1-to-2 demux; DEMUX_DROP_CNT_EN adds the saturating drop_count port
module demux1to2_stream
  import demux1to2_stream_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [N-1:0]          in_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [N-1:0]          out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [N-1:0]          out1_data,
`ifdef DEMUX_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_count,
`endif
  output logic                  drop
);

  logic to_ch0, to_ch1, to_bad;
  logic free0, free1;
  logic xfer;

  assign to_ch0 = (in_sel == SEL_CH0);
  assign to_ch1 = (in_sel == SEL_CH1);
  assign to_bad = !(to_ch0 || to_ch1);

  // Invalid codes are always accepted so a bad word can never wedge the producer.
  assign in_ready = to_ch0 ? free0 : (to_ch1 ? free1 : 1'b1);
  assign xfer     = in_valid && in_ready;

  demux_out_slot #(.N(N)) u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (xfer && to_ch0),
    .wdata (in_data),
    .ready (out0_ready),
    .free  (free0),
    .valid (out0_valid),
    .data  (out0_data)
  );

  demux_out_slot #(.N(N)) u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (xfer && to_ch1),
    .wdata (in_data),
    .ready (out1_ready),
    .free  (free1),
    .valid (out1_valid),
    .data  (out1_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else begin
      drop <= xfer && to_bad;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (xfer && to_bad && (drop_count != {DROP_CNT_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb/tb_demux1to2_stream.sv - directed bench for demux1to2_stream (drop_count checks when DEMUX_DROP_CNT_EN is defined)
module tb_demux1to2_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid, out1_ready;
  logic [31:0] out1_data;
  logic        drop;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int tests;
  int fails;

  demux1to2_stream #(.N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
`ifdef DEMUX_DROP_CNT_EN
    .drop_count (drop_count),
`endif
    .drop       (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sel = 2'b00;
    in_data = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // Reset
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    check("rst_v0", out0_valid, 0);
    check("rst_v1", out1_valid, 0);
    check("rst_d0", out0_data, 0);
    check("rst_d1", out1_data, 0);
    check("rst_drop", drop, 0);
    in_sel = 2'b00; #1 check("rst_rdy00", in_ready, 1);
    in_sel = 2'b01; #1 check("rst_rdy01", in_ready, 1);
    in_sel = 2'b10; #1 check("rst_rdy10", in_ready, 1);
`ifdef DEMUX_DROP_CNT_EN
    check("rst_cnt", drop_count, 0);
`endif

    // Route to channel 0
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hDEADBEEF; out0_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("route_v0", out0_valid, 1);
    check("route_d0", out0_data, 32'hDEADBEEF);
    check("route_v1", out1_valid, 0);
    step();
    check("route_drain_v0", out0_valid, 0);
    check("route_drain_d0", out0_data, 0);
    out0_ready = 1'b0;

    // Backpressure on channel 1
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h1;
    step();
    check("bp_v1", out1_valid, 1);
    check("bp_d1", out1_data, 32'h1);
    in_data = 32'h2;
    #1 check("bp_rdy_low", in_ready, 0);
    in_sel = 2'b00;
    #1 check("bp_isolate_rdy", in_ready, 1);
    in_sel = 2'b01;
    step();
    check("bp_hold_d1", out1_data, 32'h1);
    out1_ready = 1'b1;
    #1 check("bp_rdy_high", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_new_v1", out1_valid, 1);
    check("bp_new_d1", out1_data, 32'h2);
    step();
    check("bp_drain_v1", out1_valid, 0);
    out1_ready = 1'b0;

    // Simultaneous drain and load on channel 0
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hA;
    step();
    check("sim_a_d0", out0_data, 32'hA);
    out0_ready = 1'b1; in_data = 32'hB;
    #1 check("sim_rdy", in_ready, 1);
    step();
    in_valid = 1'b0; out0_ready = 1'b0;
    check("sim_v0", out0_valid, 1);
    check("sim_d0", out0_data, 32'hB);

    // Invalid sel while slot 0 is full and stalled
    in_valid = 1'b1; in_sel = 2'b10; in_data = 32'h5;
    #1 check("bad_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bad_drop", drop, 1);
    check("bad_d0", out0_data, 32'hB);
    check("bad_v1", out1_valid, 0);
`ifdef DEMUX_DROP_CNT_EN
    check("cnt_one", drop_count, 1);
`endif
    step();
    check("bad_drop_clr", drop, 0);
    check("bad_v0", out0_valid, 1);
`ifdef DEMUX_DROP_CNT_EN
    in_valid = 1'b1; in_sel = 2'b11;
    for (int i = 0; i < 65534; i++) step();
    in_valid = 1'b0;
    check("cnt_max", drop_count, 16'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("cnt_sat", drop_count, 16'hFFFF);
`endif

    // Asynchronous reset with both slots full and stalled
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h7;
    step();
    in_valid = 1'b0;
    check("ar_pre_v0", out0_valid, 1);
    check("ar_pre_v1", out1_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_v0", out0_valid, 0);
    check("ar_v1", out1_valid, 0);
    check("ar_d1", out1_data, 0);
    step();
    #2 rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    check("ar_post_v0", out0_valid, 0);
    check("ar_post_v1", out1_valid, 0);
    check("ar_post_d0", out0_data, 0);
`ifdef DEMUX_DROP_CNT_EN
    check("ar_cnt", drop_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
